// File: rtl/datapath_seq.sv
// datapath_seq
//   Parametrised accumulator datapath with a register file of NREGS x WIDTH,
//   an accumulator A, an 8-operation ALU with carry/zero flags, and a
//   three-state sequencer. One START runs the operand fetch, the ALU step and
//   an optional write-back. External loads go straight into the register file
//   while the sequencer is idle.
//
// Ports
//   CLK    rising-edge clock
//   CLR    synchronous active-low reset
//   M      external load data, slice i feeds R[i]
//   LD     per-register external load enable (idle only)
//   START  command strobe (idle only)
//   OP     ALU opcode
//   SRC    B-operand register index
//   DST    write-back register index
//   WE     write-back enable for the command
//   CIN    carry in for ADD
//   R      register file contents, slice i is R[i]
//   ACC    accumulator A
//   COUT   carry / no-borrow flag
//   ZERO   zero flag
//   BUSY   command in progress
//   DONE   one-cycle completion pulse
module datapath_seq #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  localparam int SELW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [NREGS*WIDTH-1:0]   M,
  input  logic [NREGS-1:0]         LD,
  input  logic                     START,
  input  logic [2:0]               OP,
  input  logic [SELW-1:0]          SRC,
  input  logic [SELW-1:0]          DST,
  input  logic                     WE,
  input  logic                     CIN,
  output logic [NREGS*WIDTH-1:0]   R,
  output logic [WIDTH-1:0]         ACC,
  output logic                     COUT,
  output logic                     ZERO,
  output logic                     BUSY,
  output logic                     DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_CLRA = 3'b111;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] acc;
  logic             cout;
  logic             zero;
  logic             busy;
  logic             done;

  logic [2:0]       op_q;
  logic [SELW-1:0]  src_q;
  logic [SELW-1:0]  dst_q;
  logic             we_q;
  logic             cin_q;

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             src_ok;
  logic             dst_ok;

  // Index range checks matter only when NREGS is not a power of two.
  always_comb begin
    src_ok = (32'(src_q) < NREGS);
    dst_ok = (32'(dst_q) < NREGS);
  end

  // Sequencer next-state: a command always walks IDLE -> EXEC -> WB -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU. Subtraction is A + ~B + 1 so the carry out directly reads as
  // "no borrow". An out-of-range source index reads as zero.
  always_comb begin
    operand_b = src_ok ? regs[src_q] : '0;
    add_sum   = {1'b0, acc} + {1'b0, operand_b} + {{WIDTH{1'b0}}, cin_q};
    sub_sum   = {1'b0, acc} + {1'b0, ~operand_b} + (WIDTH+1)'(1);
    alu_res   = '0;
    alu_c     = 1'b0;
    case (op_q)
      OP_PASS: alu_res = operand_b;
      OP_ADD:  begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
      end
      OP_SUB:  begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
      end
      OP_AND:  alu_res = acc & operand_b;
      OP_OR:   alu_res = acc | operand_b;
      OP_XOR:  alu_res = acc ^ operand_b;
      OP_SHL:  begin
        alu_res = {acc[WIDTH-2:0], 1'b0};
        alu_c   = acc[WIDTH-1];
      end
      OP_CLRA: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // State, register file, accumulator and flags. Loads and command capture
  // happen in the same idle edge, so EXEC sees a freshly loaded operand.
  // Write-back uses the accumulator value that EXEC just produced.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      acc   <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      we_q  <= 1'b0;
      cin_q <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          for (int i = 0; i < NREGS; i++) begin
            if (LD[i]) regs[i] <= M[i*WIDTH +: WIDTH];
          end
          if (START) begin
            op_q  <= OP;
            src_q <= SRC;
            dst_q <= DST;
            we_q  <= WE;
            cin_q <= CIN;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          acc  <= alu_res;
          cout <= alu_c;
          zero <= (alu_res == '0);
        end
        WB: begin
          if (we_q && dst_ok) regs[dst_q] <= acc;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Flatten the register file onto the R bus.
  always_comb begin
    R = '0;
    for (int i = 0; i < NREGS; i++) R[i*WIDTH +: WIDTH] = regs[i];
  end

  assign ACC  = acc;
  assign COUT = cout;
  assign ZERO = zero;
  assign BUSY = busy;
  assign DONE = done;

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq
//   Drives two datapath_seq instances (4x4 and 8x8) and compares them against
//   a behavioural model of the register file, accumulator and flags.
module tb_datapath_seq;

  logic CLK;

  // 4-bit, 4-register instance
  logic        clrA;
  logic [15:0] mA;
  logic [3:0]  ldA;
  logic        startA;
  logic [2:0]  opA;
  logic [1:0]  srcA, dstA;
  logic        weA, cinA;
  logic [15:0] rA;
  logic [3:0]  accA;
  logic        coutA, zeroA, busyA, doneA;

  // 8-bit, 8-register instance
  logic        clrB;
  logic [63:0] mB;
  logic [7:0]  ldB;
  logic        startB;
  logic [2:0]  opB;
  logic [2:0]  srcB, dstB;
  logic        weB, cinB;
  logic [63:0] rB;
  logic [7:0]  accB;
  logic        coutB, zeroB, busyB, doneB;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state, indexed by instance (0 = 4x4, 1 = 8x8)
  int mr [2][8];
  int macc [2];
  int mcout [2];
  int mzero [2];

  datapath_seq #(.WIDTH(4), .NREGS(4)) dutA (
    .CLK(CLK), .CLR(clrA), .M(mA), .LD(ldA), .START(startA), .OP(opA),
    .SRC(srcA), .DST(dstA), .WE(weA), .CIN(cinA), .R(rA), .ACC(accA),
    .COUT(coutA), .ZERO(zeroA), .BUSY(busyA), .DONE(doneA)
  );

  datapath_seq #(.WIDTH(8), .NREGS(8)) dutB (
    .CLK(CLK), .CLR(clrB), .M(mB), .LD(ldB), .START(startB), .OP(opB),
    .SRC(srcB), .DST(dstB), .WE(weB), .CIN(cinB), .R(rB), .ACC(accB),
    .COUT(coutB), .ZERO(zeroB), .BUSY(busyB), .DONE(doneB)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int wOf(input int cfg);
    return (cfg == 0) ? 4 : 8;
  endfunction

  function automatic int modOf(input int cfg);
    return 1 << wOf(cfg);
  endfunction

  function automatic logic [63:0] getR(input int cfg, input int i);
    if (cfg == 0) return 64'(rA[i*4 +: 4]);
    return 64'(rB[i*8 +: 8]);
  endfunction

  function automatic logic [63:0] getAcc(input int cfg);
    return (cfg == 0) ? 64'(accA) : 64'(accB);
  endfunction

  function automatic logic [63:0] getCout(input int cfg);
    return (cfg == 0) ? 64'(coutA) : 64'(coutB);
  endfunction

  function automatic logic [63:0] getZero(input int cfg);
    return (cfg == 0) ? 64'(zeroA) : 64'(zeroB);
  endfunction

  function automatic logic [63:0] getBusy(input int cfg);
    return (cfg == 0) ? 64'(busyA) : 64'(busyB);
  endfunction

  function automatic logic [63:0] getDone(input int cfg);
    return (cfg == 0) ? 64'(doneA) : 64'(doneB);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one instance; the other instance is held quiet.
  task automatic applyStimulus(input int cfg, input logic start, input logic [2:0] op,
                               input int src, input int dst, input logic we, input logic cin,
                               input logic [7:0] ld, input logic [63:0] m);
    if (cfg == 0) begin
      startA = start; opA = op; srcA = 2'(src); dstA = 2'(dst);
      weA = we; cinA = cin; ldA = ld[3:0]; mA = m[15:0];
      startB = 1'b0; ldB = '0;
    end else begin
      startB = start; opB = op; srcB = 3'(src); dstB = 3'(dst);
      weB = we; cinB = cin; ldB = ld; mB = m;
      startA = 1'b0; ldA = '0;
    end
  endtask

  task automatic setClr(input int cfg, input logic v);
    if (cfg == 0) clrA = v;
    else clrB = v;
  endtask

  task automatic modelReset(input int cfg);
    for (int i = 0; i < 8; i++) mr[cfg][i] = 0;
    macc[cfg] = 0;
    mcout[cfg] = 0;
    mzero[cfg] = 0;
  endtask

  task automatic modelLoad(input int cfg, input logic [7:0] ld, input logic [63:0] m);
    int w;
    logic [63:0] sh;
    w = wOf(cfg);
    for (int i = 0; i < w; i++) begin
      if (ld[i]) begin
        sh = m >> (i * w);
        mr[cfg][i] = int'(sh[7:0]) % modOf(cfg);
      end
    end
  endtask

  // ALU behaviour in plain integer arithmetic.
  task automatic modelExec(input int cfg, input logic [2:0] op, input int src, input logic cin);
    int a, b, md, res, c, s;
    a = macc[cfg];
    b = mr[cfg][src];
    md = modOf(cfg);
    res = 0;
    c = 0;
    case (op)
      3'd0: res = b;
      3'd1: begin s = a + b + int'(cin); res = s % md; c = (s >= md) ? 1 : 0; end
      3'd2: begin res = (a - b + md) % md; c = (a >= b) ? 1 : 0; end
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: begin res = (a * 2) % md; c = (a >= md / 2) ? 1 : 0; end
      default: res = 0;
    endcase
    macc[cfg] = res;
    mcout[cfg] = c;
    mzero[cfg] = (res == 0) ? 1 : 0;
  endtask

  task automatic checkRegs(input int cfg, input string tag);
    for (int i = 0; i < wOf(cfg); i++)
      checkOutput($sformatf("%s.R%0d", tag, i), getR(cfg, i), 64'(mr[cfg][i]));
  endtask

  // Full command: START edge, EXEC edge, WB edge. Returns just after WB,
  // with DONE high and the sequencer idle again.
  task automatic runCmd(input int cfg, input string tag, input logic [2:0] op, input int src,
                        input int dst, input logic we, input logic cin,
                        input logic [7:0] ld, input logic [63:0] m);
    applyStimulus(cfg, 1'b1, op, src, dst, we, cin, ld, m);
    modelLoad(cfg, ld, m);
    tick();
    checkOutput({tag, ".busy1"}, getBusy(cfg), 64'd1);
    checkOutput({tag, ".done1"}, getDone(cfg), 64'd0);
    applyStimulus(cfg, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    tick();
    modelExec(cfg, op, src, cin);
    checkOutput({tag, ".acc"}, getAcc(cfg), 64'(macc[cfg]));
    checkOutput({tag, ".cout"}, getCout(cfg), 64'(mcout[cfg]));
    checkOutput({tag, ".zero"}, getZero(cfg), 64'(mzero[cfg]));
    checkOutput({tag, ".busy2"}, getBusy(cfg), 64'd1);
    tick();
    if (we) mr[cfg][dst] = macc[cfg];
    checkOutput({tag, ".done"}, getDone(cfg), 64'd1);
    checkOutput({tag, ".busy3"}, getBusy(cfg), 64'd0);
    checkRegs(cfg, tag);
  endtask

  task automatic loadOnly(input int cfg, input logic [7:0] ld, input logic [63:0] m);
    applyStimulus(cfg, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, ld, m);
    modelLoad(cfg, ld, m);
    tick();
    applyStimulus(cfg, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
  endtask

  // START and LD held during EXEC and WB must be ignored; afterwards a load
  // and START in the same idle cycle must feed the new value to EXEC.
  task automatic busyIgnore(input int cfg);
    int old0;
    old0 = mr[cfg][0];
    applyStimulus(cfg, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    tick();
    applyStimulus(cfg, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 8'h01, 64'h0A);
    tick();
    modelExec(cfg, 3'd0, 0, 1'b0);
    checkOutput("ign.acc", getAcc(cfg), 64'(macc[cfg]));
    tick();
    checkOutput("ign.done", getDone(cfg), 64'd1);
    applyStimulus(cfg, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    checkOutput("ign.R0", getR(cfg, 0), 64'(old0));
    tick();
    checkOutput("ign.noDone", getDone(cfg), 64'd0);
    checkOutput("ign.noBusy", getBusy(cfg), 64'd0);
    checkOutput("ign.R0b", getR(cfg, 0), 64'(old0));
    runCmd(cfg, "ldStart", 3'd0, 3, 0, 1'b0, 1'b0, 8'h08, 64'h5 << (3 * wOf(cfg)));
    checkOutput("ldStart.acc5", getAcc(cfg), 64'h5);
    tick();
    checkOutput("ldStart.doneOnce", getDone(cfg), 64'd0);
  endtask

  task automatic resetInWb(input int cfg);
    applyStimulus(cfg, 1'b1, 3'd1, 0, 1, 1'b1, 1'b1, 8'd0, 64'd0);
    tick();
    applyStimulus(cfg, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    tick();
    setClr(cfg, 1'b0);
    tick();
    modelReset(cfg);
    checkOutput("rst.R1", getR(cfg, 1), 64'd0);
    checkOutput("rst.acc", getAcc(cfg), 64'd0);
    checkOutput("rst.done", getDone(cfg), 64'd0);
    checkOutput("rst.busy", getBusy(cfg), 64'd0);
    setClr(cfg, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("rst.noDone%0d", k), getDone(cfg), 64'd0);
    end
  endtask

  task automatic randomCmds(input int cfg, input int count);
    int n;
    logic [2:0] op;
    logic [7:0] ld;
    logic [63:0] m;
    n = wOf(cfg);
    for (int k = 0; k < count; k++) begin
      op = 3'($urandom_range(0, 7));
      ld = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
      m = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) loadOnly(cfg, 8'($urandom), {$urandom, $urandom});
      runCmd(cfg, $sformatf("rnd%0d_%0d", cfg, k), op, $urandom_range(0, n - 1),
             $urandom_range(0, n - 1), 1'($urandom), 1'($urandom), ld, m);
    end
  endtask

  initial begin
    clrA = 1'b0;
    clrB = 1'b0;
    applyStimulus(0, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    applyStimulus(1, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    modelReset(0);
    modelReset(1);

    $display("[TB] reset");
    tick();
    tick();
    clrA = 1'b1;
    clrB = 1'b1;
    for (int c = 0; c < 2; c++) begin
      checkRegs(c, $sformatf("reset%0d", c));
      checkOutput("reset.acc", getAcc(c), 64'd0);
      checkOutput("reset.busy", getBusy(c), 64'd0);
      checkOutput("reset.done", getDone(c), 64'd0);
      checkOutput("reset.zero", getZero(c), 64'd0);
      checkOutput("reset.cout", getCout(c), 64'd0);
    end

    $display("[TB] 4x4 PASS then ADD with carry");
    loadOnly(0, 8'h03, 64'h0089);
    runCmd(0, "pass", 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    checkOutput("pass.acc9", getAcc(0), 64'h9);
    runCmd(0, "add", 3'd1, 1, 2, 1'b1, 1'b1, 8'd0, 64'd0);
    checkOutput("add.acc2", getAcc(0), 64'h2);
    checkOutput("add.cout1", getCout(0), 64'd1);
    checkOutput("add.R2", getR(0, 2), 64'h2);
    tick();
    checkOutput("add.doneOnce", getDone(0), 64'd0);

    $display("[TB] 4x4 SUB to zero and with borrow");
    loadOnly(0, 8'h0A, 64'h1030);
    runCmd(0, "pass3", 3'd0, 1, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    runCmd(0, "sub0", 3'd2, 1, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    checkOutput("sub0.acc", getAcc(0), 64'h0);
    checkOutput("sub0.zero", getZero(0), 64'd1);
    checkOutput("sub0.cout", getCout(0), 64'd1);
    runCmd(0, "subB", 3'd2, 3, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    checkOutput("subB.acc", getAcc(0), 64'hF);
    checkOutput("subB.cout", getCout(0), 64'd0);
    checkOutput("subB.zero", getZero(0), 64'd0);

    $display("[TB] 4x4 busy-ignore and reset in write-back");
    busyIgnore(0);
    resetInWb(0);

    $display("[TB] 8x8 directed");
    loadOnly(1, 8'h03, 64'h01FF);
    runCmd(1, "pass8", 3'd0, 0, 0, 1'b0, 1'b0, 8'd0, 64'd0);
    runCmd(1, "add8", 3'd1, 1, 7, 1'b1, 1'b0, 8'd0, 64'd0);
    checkOutput("add8.acc", getAcc(1), 64'h00);
    checkOutput("add8.cout", getCout(1), 64'd1);
    checkOutput("add8.zero", getZero(1), 64'd1);
    loadOnly(1, 8'h04, 64'h5A0000);
    runCmd(1, "wr7", 3'd0, 2, 7, 1'b1, 1'b0, 8'd0, 64'd0);
    checkOutput("wr7.R7", getR(1, 7), 64'h5A);
    busyIgnore(1);

    $display("[TB] randomized commands");
    randomCmds(0, 30);
    randomCmds(1, 30);
    resetInWb(1);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
